// File: rtl/data_sync_tx.sv
// Source-domain half of a bus-enable synchronizer: captures a word, holds it on
// unsync_bus and frames it with a level bus_enable (timed or four-phase ack).
module data_sync_tx #(
    parameter int BUS_WIDTH   = 8,
    parameter int NUM_STAGES  = 2,
    parameter int ACK_MODE    = 0,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 ack_async,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    // S_TAIL is the GAP window in timed mode and RELEASE in ack mode.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_REQ  = 2'd2,
        S_TAIL = 2'd3
    } state_t;

    state_t                 r_state;
    logic [BUS_WIDTH-1:0]   r_bus;
    logic                   r_en;
    logic                   r_done;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_STAGES-1:0]  r_ack_sync;

    state_t                 w_state_nxt;
    logic [BUS_WIDTH-1:0]   w_bus_nxt;
    logic                   w_en_nxt;
    logic                   w_done_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_ack_sync;

    assign w_ack_sync = r_ack_sync[NUM_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], ack_async};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_bus   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bus   <= w_bus_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Handshake: a word is taken on any edge where tx_valid && tx_ready;
    // the bus only changes on that edge, one full cycle before bus_enable rises.
    always_comb begin
        w_state_nxt = r_state;
        w_bus_nxt   = r_bus;
        w_en_nxt    = r_en;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = S_LOAD;
                    w_bus_nxt   = tx_data;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_REQ;
                w_en_nxt    = 1'b1;
                w_cnt_nxt   = '0;
            end
            S_REQ: begin
                if (ACK_MODE != 0) begin
                    if (w_ack_sync) begin
                        w_state_nxt = S_TAIL;
                        w_en_nxt    = 1'b0;
                    end
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_TAIL;
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_TAIL: begin
                if (ACK_MODE != 0) begin
                    if (!w_ack_sync) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign tx_ready   = (r_state == S_IDLE) && !RST;
    assign busy       = (r_state != S_IDLE);
    assign unsync_bus = r_bus;
    assign bus_enable = r_en;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: a timed-mode and an ack-mode instance share one clock
// and are checked every cycle against a timestamp-based transfer model.
module tb_data_sync_tx;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int G  = 3;
    localparam int NS = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a_data, b_data;
    logic         a_valid, b_valid, b_ack;

    logic         a_ready, a_en, a_busy, a_done;
    logic [W-1:0] a_bus;
    logic [1:0]   a_dbg;
    logic         b_ready, b_en, b_busy, b_done;
    logic [W-1:0] b_bus;
    logic [1:0]   b_dbg;

    always #5 clk = ~clk;

    data_sync_tx #(.BUS_WIDTH(W), .NUM_STAGES(NS), .ACK_MODE(0),
                   .HOLD_CYCLES(H), .GAP_CYCLES(G)) u_timed (
        .CLK(clk), .RST(rst), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .ack_async(b_ack), .unsync_bus(a_bus),
        .bus_enable(a_en), .busy(a_busy), .done(a_done), .dbg_state(a_dbg));

    data_sync_tx #(.BUS_WIDTH(W), .NUM_STAGES(NS), .ACK_MODE(1),
                   .HOLD_CYCLES(H), .GAP_CYCLES(G)) u_ack (
        .CLK(clk), .RST(rst), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .ack_async(b_ack), .unsync_bus(b_bus),
        .bus_enable(b_en), .busy(b_busy), .done(b_done), .dbg_state(b_dbg));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: each transfer is described by the edge numbers of its events.
    int           t = 0;
    int           last_rst = -1000;
    logic         ack_hist[0:8191];
    int           ma_acc = -1;
    logic [W-1:0] ma_bus = '0;
    int           mb_acc = -1, mb_fall = -1, mb_done = -1;
    logic [W-1:0] mb_bus = '0;
    int           a_done_cnt = 0, b_done_cnt = 0;

    task automatic model_edge();
        logic a_idle_prev, b_idle_prev, seen;
        t++;
        ack_hist[t] = b_ack;
        if (rst) begin
            ma_acc = -1; ma_bus = '0;
            mb_acc = -1; mb_fall = -1; mb_done = -1; mb_bus = '0;
            last_rst = t;
        end else begin
            a_idle_prev = (ma_acc < 0) || (t - 1 >= ma_acc + 1 + H + G);
            if (a_idle_prev && a_valid) begin
                ma_acc = t;
                ma_bus = a_data;
            end
            seen = (t - NS > last_rst && t - NS >= 1) ? ack_hist[t-NS] : 1'b0;
            b_idle_prev = (mb_acc < 0) || (mb_done >= 0 && mb_done <= t - 1);
            if (mb_acc >= 0 && mb_fall < 0 && t >= mb_acc + 2 && seen)
                mb_fall = t;
            else if (mb_fall >= 0 && mb_done < 0 && t > mb_fall && !seen)
                mb_done = t;
            if (b_idle_prev && b_valid) begin
                mb_acc = t; mb_fall = -1; mb_done = -1;
                mb_bus = b_data;
            end
        end
    endtask

    task automatic compare();
        logic ea_en, ea_busy, ea_done, eb_en, eb_busy, eb_done;
        ea_en   = (ma_acc >= 0) && (t >= ma_acc + 1) && (t <= ma_acc + H);
        ea_busy = (ma_acc >= 0) && (t < ma_acc + 1 + H + G);
        ea_done = (ma_acc >= 0) && (t == ma_acc + 1 + H + G);
        eb_en   = (mb_acc >= 0) && (t >= mb_acc + 1) && (mb_fall < 0 || t < mb_fall);
        eb_busy = (mb_acc >= 0) && (mb_done < 0 || t < mb_done);
        eb_done = (mb_acc >= 0) && (mb_done == t);
        chk("a_en",    32'(a_en),    32'(ea_en));
        chk("a_busy",  32'(a_busy),  32'(ea_busy));
        chk("a_done",  32'(a_done),  32'(ea_done));
        chk("a_bus",   32'(a_bus),   32'(ma_bus));
        chk("a_ready", 32'(a_ready), 32'(!ea_busy && !rst));
        chk("a_dbg",   32'(a_dbg != 2'd0), 32'(ea_busy));
        chk("b_en",    32'(b_en),    32'(eb_en));
        chk("b_busy",  32'(b_busy),  32'(eb_busy));
        chk("b_done",  32'(b_done),  32'(eb_done));
        chk("b_bus",   32'(b_bus),   32'(mb_bus));
        chk("b_ready", 32'(b_ready), 32'(!eb_busy && !rst));
        chk("b_dbg",   32'(b_dbg != 2'd0), 32'(eb_busy));
        if (a_done === 1'b1) a_done_cnt++;
        if (b_done === 1'b1) b_done_cnt++;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            compare();
        end
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_data = 8'hFF;
        b_valid = 1'b1; b_data = 8'hFF;
        b_ack = 1'b0;
        #2;
        step(2);
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("ready_after_rst_a", 32'(a_ready), 32'd1);
        chk("ready_after_rst_b", 32'(b_ready), 32'd1);
        step(2);

        // timed single transfer
        a_valid = 1'b1; a_data = 8'hA5;
        step(1);
        a_valid = 1'b0; a_data = 8'h00;
        step(12);

        // timed back-to-back with tx_valid held
        a_done_cnt = 0;
        a_valid = 1'b1; a_data = 8'h01;
        step(1);
        a_data = 8'h02;
        step(17);
        a_valid = 1'b0;
        step(10);
        chk("b2b_done_cnt", 32'(a_done_cnt), 32'd2);

        // ack mode normal four-phase transfer
        b_done_cnt = 0;
        b_valid = 1'b1; b_data = 8'h3C;
        step(1);
        b_valid = 1'b0; b_data = 8'h00;
        step(3);
        b_ack = 1'b1;
        step(6);
        b_ack = 1'b0;
        step(6);
        chk("ack_done_cnt", 32'(b_done_cnt), 32'd1);

        // spurious ack pulse in idle, then stale ack held over an accept
        b_ack = 1'b1; step(1);
        b_ack = 1'b0; step(5);
        b_ack = 1'b1; step(4);
        b_valid = 1'b1; b_data = 8'h5A;
        step(1);
        b_valid = 1'b0;
        step(4);
        b_ack = 1'b0;
        step(6);

        // reset in the middle of a transfer on both instances
        a_done_cnt = 0; b_done_cnt = 0;
        a_valid = 1'b1; a_data = 8'hC3;
        b_valid = 1'b1; b_data = 8'h77;
        step(1);
        a_valid = 1'b0; b_valid = 1'b0;
        step(3);
        rst = 1'b1; step(1);
        rst = 1'b0; step(10);
        chk("abort_no_done_a", 32'(a_done_cnt), 32'd0);
        chk("abort_no_done_b", 32'(b_done_cnt), 32'd0);
        a_valid = 1'b1; a_data = 8'hA5;
        step(1);
        a_valid = 1'b0;
        step(12);

        // randomized traffic with a loosely-following ack responder
        for (int i = 0; i < 2000; i++) begin
            a_valid = ($urandom_range(0, 2) != 0);
            a_data  = W'($urandom);
            b_valid = ($urandom_range(0, 2) != 0);
            b_data  = W'($urandom);
            if ($urandom_range(0, 2) == 0) b_ack = b_en;
            if ($urandom_range(0, 49) == 0) b_ack = ~b_ack;
            rst = ($urandom_range(0, 149) == 0);
            step(1);
        end
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; b_ack = 1'b0;
        step(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
